// File: rtl/block_assembler_if.sv
// Byte-stream / encryption-controller handshake bundle for block_assembler.
// master = byte source plus AES controller side, slave = the assembler itself.
interface block_assembler_if;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         flush;
    logic         byte_ready;
    logic         enc_busy;
    logic         enable_encrypt;
    logic [127:0] block_out;
    logic         hold_valid;
    logic         pad_done;

    modport master (
        output byte_in, byte_valid, flush, enc_busy,
        input  byte_ready, enable_encrypt, block_out, hold_valid, pad_done
    );

    modport slave (
        input  byte_in, byte_valid, flush, enc_busy,
        output byte_ready, enable_encrypt, block_out, hold_valid, pad_done
    );
endinterface

// File: rtl/block_assembler.sv
// Packs a byte stream into 128-bit AES blocks through a staging/holding double buffer.
// Define PKCS7_PAD_EN for PKCS#7 padding (and full-pad empty flush); default pads with 0x00.
module block_assembler #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic            clk,
    input  logic            n_rst,
    block_assembler_if.slave bus
);

    localparam int unsigned BW = 8 * BLOCK_BYTES;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        HIdle  = 2'd0,
        HIssue = 2'd1,
        HBusy  = 2'd2
    } h_state_e;

    h_state_e         state_q, state_d;
    logic [BW-1:0]    stage_q, stage_d;
    logic [CNT_W-1:0] stage_cnt_q, stage_cnt_d;
    logic             flush_mark_q, flush_mark_d;
    logic [BW-1:0]    block_out_q;
    logic             hold_valid_q;
    logic             pad_done_q;

    logic             free;
    logic             xfer;
    logic             byte_ready;
    logic             flush_act;
    logic [CNT_W-1:0] fill_cnt;
    logic [7:0]       pad_byte;

    // The hold is released on the edge where the controller drops busy; a full stage
    // may move into it on that same edge.
    assign free       = (state_q == HBusy) && !bus.enc_busy;
    assign xfer       = (stage_cnt_q == FULL) && (!hold_valid_q || free);
    assign byte_ready = (stage_cnt_q != FULL) && !xfer;

    always_comb begin
        stage_d      = stage_q;
        stage_cnt_d  = stage_cnt_q;
        flush_mark_d = flush_mark_q;
        fill_cnt     = stage_cnt_q;
        flush_act    = 1'b0;
        pad_byte     = 8'h00;
        if (xfer) begin
            stage_cnt_d  = '0;
            flush_mark_d = 1'b0;
        end else if (byte_ready) begin
            if (bus.byte_valid) begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    if (CNT_W'(i) == stage_cnt_q) stage_d[BW-1-8*i -: 8] = bus.byte_in;
                end
                fill_cnt = stage_cnt_q + CNT_W'(1);
            end
`ifdef PKCS7_PAD_EN
            flush_act = bus.flush;
            pad_byte  = 8'(FULL - fill_cnt);
`else
            // An empty flush carries no data and is dropped.
            flush_act = bus.flush && (fill_cnt != '0);
            pad_byte  = 8'h00;
`endif
            if (flush_act) begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    if (CNT_W'(i) >= fill_cnt) stage_d[BW-1-8*i -: 8] = pad_byte;
                end
                fill_cnt     = FULL;
                flush_mark_d = 1'b1;
            end
            stage_cnt_d = fill_cnt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_q      <= '0;
            stage_cnt_q  <= '0;
            flush_mark_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            stage_cnt_q  <= stage_cnt_d;
            flush_mark_q <= flush_mark_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            block_out_q  <= '0;
            hold_valid_q <= 1'b0;
            pad_done_q   <= 1'b0;
        end else if (xfer) begin
            block_out_q  <= stage_q;
            hold_valid_q <= 1'b1;
            pad_done_q   <= flush_mark_q;
        end else if (free) begin
            hold_valid_q <= 1'b0;
            pad_done_q   <= 1'b0;
        end
    end

    // Hold FSM: state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= HIdle;
        else        state_q <= state_d;
    end

    // Hold FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            HIdle:   if (xfer) state_d = HIssue;
            HIssue:  if (!bus.enc_busy) state_d = HBusy;
            HBusy:   if (!bus.enc_busy) state_d = xfer ? HIssue : HIdle;
            default: state_d = HIdle;
        endcase
    end

    // Hold FSM: outputs
    always_comb begin
        bus.enable_encrypt = (state_q == HIssue) && !bus.enc_busy;
    end

    assign bus.byte_ready = byte_ready;
    assign bus.block_out  = block_out_q;
    assign bus.hold_valid = hold_valid_q;
    assign bus.pad_done   = pad_done_q;

endmodule

// File: tb/tb_block_assembler.sv
// Directed bench for block_assembler: vector table plus backpressure and mid-block reset.
// Expected blocks follow PKCS7_PAD_EN when the macro is defined for the build.
module tb_block_assembler;

    logic clk;
    logic n_rst;
    int   n_tests;
    int   n_fail;
    int   busy_len;
    logic [7:0] busy_cnt;

    block_assembler_if bus ();

    block_assembler dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: busy for busy_len cycles after each start pulse.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)                  busy_cnt <= 8'd0;
        else if (bus.enable_encrypt) busy_cnt <= 8'(busy_len);
        else if (busy_cnt != 8'd0)   busy_cnt <= busy_cnt - 8'd1;
    end
    assign bus.enc_busy = (busy_cnt != 8'd0);

    typedef struct {
        logic [7:0]   base;
        int           step;
        int           nbytes;
        int           fmode;     // 0 none, 1 flush after, 2 flush with last byte
        logic [127:0] exp_block;
        logic         exp_pad;
        logic         exp_pulse;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        bus.byte_valid = 1'b0;
        bus.flush = 1'b0;
        bus.byte_in = 8'h00;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic v, input logic f);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.byte_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", 128'(bus.byte_ready), 128'd1);
        bus.byte_in    = b;
        bus.byte_valid = v;
        bus.flush      = f;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic wait_pulse(input int max_cyc, output int lat);
        lat = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (bus.enable_encrypt) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_free();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!bus.hold_valid) break;
        end
    endtask

    initial begin
        int   lat;
        logic saw_ready;
        logic unstable;
        logic prev_busy;
        logic prev_ready;
        n_tests = 0;
        n_fail  = 0;
        busy_len = 3;
        n_rst = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.flush = 1'b0;

        vecs[0] = '{8'h00, 1, 16, 0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0, 1'b1};
        vecs[2] = '{8'h46, 1, 16, 2, 128'h46474849_4a4b4c4d_4e4f5051_52535455, 1'b1, 1'b1};
`ifdef PKCS7_PAD_EN
        vecs[1] = '{8'haa, 0, 5, 1, 128'haaaaaaaa_aa0b0b0b_0b0b0b0b_0b0b0b0b, 1'b1, 1'b1};
        vecs[3] = '{8'h7e, 0, 1, 1, 128'h7e0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 0, 0, 1, 128'h10101010_10101010_10101010_10101010, 1'b1, 1'b1};
        vecs[5] = '{8'h01, 1, 15, 1, 128'h01020304_05060708_090a0b0c_0d0e0f01, 1'b1, 1'b1};
        vecs[6] = '{8'h33, 0, 3, 2, 128'h3333330d_0d0d0d0d_0d0d0d0d_0d0d0d0d, 1'b1, 1'b1};
`else
        vecs[1] = '{8'haa, 0, 5, 1, 128'haaaaaaaa_aa000000_00000000_00000000, 1'b1, 1'b1};
        vecs[3] = '{8'h7e, 0, 1, 1, 128'h7e000000_00000000_00000000_00000000, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 0, 0, 1, 128'h0, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1, 15, 1, 128'h01020304_05060708_090a0b0c_0d0e0f00, 1'b1, 1'b1};
        vecs[6] = '{8'h33, 0, 3, 2, 128'h33333300_00000000_00000000_00000000, 1'b1, 1'b1};
`endif

        // Reset state
        @(negedge clk);
        #1;
        check("rst_block_out", bus.block_out, 128'h0);
        check("rst_hold_valid", 128'(bus.hold_valid), 128'd0);
        check("rst_enable", 128'(bus.enable_encrypt), 128'd0);
        check("rst_pad_done", 128'(bus.pad_done), 128'd0);
        check("rst_byte_ready", 128'(bus.byte_ready), 128'd1);
        @(negedge clk);
        n_rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            busy_len = 3;
            do_reset();
            for (int j = 0; j < vecs[v].nbytes; j++) begin
                send(8'(int'(vecs[v].base) + vecs[v].step * j), 1'b1,
                     (vecs[v].fmode == 2) && (j == vecs[v].nbytes - 1));
            end
            if (vecs[v].fmode == 1) send(8'h00, 1'b0, 1'b1);
            wait_pulse(20, lat);
            if (vecs[v].exp_pulse) begin
                check($sformatf("v%0d_latency", v), 128'(lat), 128'd2);
                check($sformatf("v%0d_block", v), bus.block_out, vecs[v].exp_block);
                check($sformatf("v%0d_pad_done", v), 128'(bus.pad_done), 128'(vecs[v].exp_pad));
                check($sformatf("v%0d_hold_valid", v), 128'(bus.hold_valid), 128'd1);
                @(negedge clk);
                check($sformatf("v%0d_pulse_width", v), 128'(bus.enable_encrypt), 128'd0);
                wait_free();
                check($sformatf("v%0d_freed", v), 128'(bus.hold_valid), 128'd0);
                check($sformatf("v%0d_pad_clr", v), 128'(bus.pad_done), 128'd0);
            end else begin
                check($sformatf("v%0d_no_pulse", v), 128'(lat), 128'(-1));
                check($sformatf("v%0d_no_hold", v), 128'(bus.hold_valid), 128'd0);
                check($sformatf("v%0d_ready", v), 128'(bus.byte_ready), 128'd1);
            end
        end

        // Backpressure: 32 bytes, long controller busy
        busy_len = 23;
        do_reset();
        for (int j = 0; j < 32; j++) send(8'(j), 1'b1, 1'b0);
        saw_ready  = 1'b0;
        unstable   = 1'b0;
        prev_busy  = 1'b1;
        prev_ready = 1'b1;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.enable_encrypt) begin
                lat = k;
                break;
            end
            if (bus.byte_ready) saw_ready = 1'b1;
            if (bus.block_out !== 128'h00010203_04050607_08090a0b_0c0d0e0f) unstable = 1'b1;
            prev_busy  = bus.enc_busy;
            prev_ready = bus.byte_ready;
        end
        check("bp_second_pulse", 128'(lat > 0), 128'd1);
        check("bp_ready_held_low", 128'(saw_ready), 128'd0);
        check("bp_hold_stable", 128'(unstable), 128'd0);
        check("bp_busy_fell_before", 128'(prev_busy), 128'd0);
        check("bp_ready_low_before", 128'(prev_ready), 128'd0);
        check("bp_block2", bus.block_out, 128'h10111213_14151617_18191a1b_1c1d1e1f);
        check("bp_ready_after", 128'(bus.byte_ready), 128'd1);
        check("bp_pad_done", 128'(bus.pad_done), 128'd0);

        // Reset in the middle of a block
        busy_len = 3;
        do_reset();
        for (int j = 0; j < 8; j++) send(8'(8'hc0 + j), 1'b1, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mid_rst_block_out", bus.block_out, 128'h0);
        check("mid_rst_hold_valid", 128'(bus.hold_valid), 128'd0);
        check("mid_rst_enable", 128'(bus.enable_encrypt), 128'd0);
        check("mid_rst_pad_done", 128'(bus.pad_done), 128'd0);
        check("mid_rst_ready", 128'(bus.byte_ready), 128'd1);
        @(negedge clk);
        n_rst = 1'b1;
        wait_pulse(10, lat);
        check("mid_rst_no_pulse", 128'(lat), 128'(-1));
        for (int j = 0; j < 16; j++) send(8'(8'hf0 + j), 1'b1, 1'b0);
        wait_pulse(20, lat);
        check("mid_rst_latency", 128'(lat), 128'd2);
        check("mid_rst_block", bus.block_out, 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff);
        check("mid_rst_pad", 128'(bus.pad_done), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/block_assembler.md
Name: block_assembler

Overview:
- Upstream feeder for the AES encryption controller.
- Packs the SD-side byte stream into 128-bit plaintext blocks and pads the final partial block on flush.
- Double-buffered: a staging register fills while the holding register is being encrypted.
- Drives enable_encrypt to the controller and holds block_out stable while enc_busy is high.

Parameters:
- BLOCK_BYTES, 16, bytes per AES block; fixed at 16, other values unsupported.
- CNT_W, 5, width of the staging byte counter (0..16).

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- byte_in  input  8  plaintext byte
- byte_valid  input  1  byte_in valid; accepted when byte_valid && byte_ready
- flush  input  1  end-of-message request; accepted when flush && byte_ready
- byte_ready  output  1  staging can accept a byte/flush this cycle
- enc_busy  input  1  controller busy flag (0 only in controller IDLE)
- enable_encrypt  output  1  one-cycle start pulse to controller
- block_out  output  128  holding register; first byte of block at [127:120]
- hold_valid  output  1  holding register occupied
- pad_done  output  1  current hold block was produced by a flush

Behaviour:
- Reset (async, n_rst=0): stage=0, stage_cnt=0, block_out=0, hold_valid=0, enable_encrypt=0, pad_done=0, state=H_IDLE.
- byte_ready = (stage_cnt != 16) && !xfer_cycle, where xfer_cycle means staging is moving to hold this cycle.
- Byte accept: byte i of the block (i = stage_cnt) is written to stage[127-8i -: 8], and stage_cnt increments.
- Flush accept with 0 < stage_cnt < 16:
  - The remaining bytes are filled per pad rule and stage_cnt is set to 16 in the same cycle.
  - A flush_mark flag is set.
- Flush and byte_valid in the same cycle: the byte is stored first, then the padding covers the bytes after it.
  - If that byte completes the block, no padding is applied and flush_mark is still set.
- Flush with stage_cnt == 0: behaviour depends on the macro (see Optional Feature).
- Transfer: when stage_cnt == 16 and hold_valid == 0 at a clock edge:
  - block_out <= stage, hold_valid <= 1, pad_done <= flush_mark.
  - stage_cnt <= 0, flush_mark <= 0.
  - byte_ready is 0 during that cycle.
- When staging is full and hold is occupied, byte_ready stays 0 until the hold is freed.
- Hold FSM:
  - H_IDLE: go to H_ISSUE when hold_valid becomes 1.
  - H_ISSUE: if enc_busy == 0, drive enable_encrypt = 1 for exactly this cycle and go to H_BUSY. Otherwise stay in H_ISSUE with enable_encrypt = 0.
  - H_BUSY: wait for enc_busy == 1 then 0. The first H_BUSY cycle sees enc_busy = 1, because the controller enters WAIT0 the cycle after the pulse. On enc_busy == 0: hold_valid <= 0, pad_done <= 0, go to H_IDLE.
- block_out does not change from H_ISSUE through H_BUSY.
- A transfer may occur in the same edge that frees the hold.
- Latency: the 16th byte is accepted at edge E; the transfer happens at E+1; enable_encrypt is high in the cycle after E+1, provided enc_busy = 0.
- Reset mid-block: all partial staging and hold data are discarded, and no enable_encrypt pulse follows.
- Illegal FSM encodings return to H_IDLE.

Optional Feature:
- Macro: PKCS7_PAD_EN.
- Defined:
  - Pad bytes = 16 - stage_cnt (PKCS#7).
  - Flush at stage_cnt == 0 produces a full block of 0x10 with pad_done = 1.
- Undefined:
  - Pad bytes = 0x00.
  - Flush at stage_cnt == 0 is accepted and ignored: no block is produced.

Test Plan:
- Single block: bytes 0x00..0x0F back-to-back, enc_busy model idle → block_out = 0x000102..0F, hold_valid = 1, enable_encrypt high for exactly 1 cycle, 2 cycles after the 16th byte is accepted.
- Backpressure: 32 bytes back-to-back, controller model holds enc_busy for 23 cycles → byte_ready = 0 after the 32nd byte until enc_busy falls. The second block transfers on the freeing edge and the second pulse follows.
- Partial flush: 5 bytes 0xAA then flush → bytes 5..15 are 0x0B (PKCS7_PAD_EN) or 0x00 (without), pad_done = 1.
- Flush coincident with the 16th byte 0x55 → no padding, last byte 0x55, pad_done = 1.
- Empty flush: flush at stage_cnt = 0 → an all-0x10 block (PKCS7_PAD_EN) or no enable_encrypt pulse (without).
- Reset mid-op: 8 bytes accepted, assert n_rst = 0 for 1 cycle → all outputs at reset values, and the next 16 bytes form a clean block.
